// File: rtl/upcounter_bank_pkg.sv
// upcounter_bank_pkg: shared sizing helpers for the upcounter_bank slice.
//   num_words(bw, rbw) : read words needed to cover a bw-bit snapshot.
//   idx_w(n)           : index width for n entries, never less than 1.
// The top derives CH_IDX_W = idx_w(N_CH) and WORD_IDX_W = idx_w(NUM_WORDS)
// from these functions.
package upcounter_bank_pkg;

  function automatic int num_words(input int bw, input int rbw);
    return (bw + rbw - 1) / rbw;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/upcounter_bank_ch.sv
// upcounter_bank_ch: one counter channel.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : zero the counter (drops this cycle's increment)
//   i_inc        : increment amount for this cycle
//   o_cnt        : current counter value
//   o_ovf        : sticky overflow flag (only with UPCOUNTER_BANK_OVF_FLAG_EN)
// SATURATE=1 clamps at all-ones, SATURATE=0 wraps modulo 2^BIT_WIDTH.
module upcounter_bank_ch import upcounter_bank_pkg::*; #(
  parameter int       BIT_WIDTH = 40,
  parameter int       INC_WIDTH = 1,
  parameter bit       SATURATE  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic [INC_WIDTH-1:0] i_inc,
`ifdef UPCOUNTER_BANK_OVF_FLAG_EN
  output logic                 o_ovf,
`endif
  output logic [BIT_WIDTH-1:0] o_cnt
);

  logic [BIT_WIDTH-1:0] r_cnt;
  logic [BIT_WIDTH:0]   w_sum;
  logic                 w_carry;
  logic [BIT_WIDTH-1:0] w_next;

  // One extra bit catches the carry out for both wrap and clamp.
  assign w_sum   = {1'b0, r_cnt} + (BIT_WIDTH+1)'(i_inc);
  assign w_carry = w_sum[BIT_WIDTH];
  assign w_next  = (w_carry && SATURATE) ? '1 : w_sum[BIT_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else              r_cnt <= w_next;
  end

  assign o_cnt = r_cnt;

`ifdef UPCOUNTER_BANK_OVF_FLAG_EN
  logic r_ovf;
  // Sticky; clear beats a same-cycle overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) r_ovf <= 1'b0;
    else if (w_carry)     r_ovf <= 1'b1;
  end
  assign o_ovf = r_ovf;
`endif

endmodule

// File: rtl/upcounter_bank.sv
// upcounter_bank: N_CH up-counters with atomic snapshot and word read port.
//   clk_i, rst_i : clock, synchronous active-high reset
//   countup_i    : per-channel increment, slice c = [c*INC_WIDTH +: INC_WIDTH]
//   latch_i      : copy all live counters into the snapshot registers
//   clear_i      : per-channel counter clear (snapshot untouched)
//   rd_req_i, rd_ch_i, rd_word_i : read request, one-cycle latency
//   rd_valid_o, rd_data_o, rd_err_o : read response; data/err hold when idle
//   ovf_o        : sticky per-channel overflow (only with
//                  UPCOUNTER_BANK_OVF_FLAG_EN defined)
// Reads always come from the snapshot so a multi-word value is consistent.
module upcounter_bank import upcounter_bank_pkg::*; #(
  parameter int              N_CH           = 8,
  parameter int              BIT_WIDTH      = 40,
  parameter int              READ_BIT_WIDTH = 16,
  parameter int              INC_WIDTH      = 1,
  parameter logic [N_CH-1:0] SATURATE_MASK  = '0,
  parameter int              CH_IDX_W       = idx_w(N_CH),
  parameter int              WORD_IDX_W     = idx_w(num_words(BIT_WIDTH, READ_BIT_WIDTH))
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_CH*INC_WIDTH-1:0] countup_i,
  input  logic                      latch_i,
  input  logic [N_CH-1:0]           clear_i,
  input  logic                      rd_req_i,
  input  logic [CH_IDX_W-1:0]       rd_ch_i,
  input  logic [WORD_IDX_W-1:0]     rd_word_i,
  output logic                      rd_valid_o,
  output logic [READ_BIT_WIDTH-1:0] rd_data_o,
`ifdef UPCOUNTER_BANK_OVF_FLAG_EN
  output logic [N_CH-1:0]           ovf_o,
`endif
  output logic                      rd_err_o
);

  localparam int NUM_WORDS = num_words(BIT_WIDTH, READ_BIT_WIDTH);
  localparam int PAD_W     = NUM_WORDS * READ_BIT_WIDTH;

  logic [N_CH-1:0][BIT_WIDTH-1:0] w_cnt;
  logic [N_CH-1:0][BIT_WIDTH-1:0] r_snap;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    upcounter_bank_ch #(
      .BIT_WIDTH (BIT_WIDTH),
      .INC_WIDTH (INC_WIDTH),
      .SATURATE  (SATURATE_MASK[c])
    ) u_ch (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_clear (clear_i[c]),
      .i_inc   (countup_i[c*INC_WIDTH +: INC_WIDTH]),
`ifdef UPCOUNTER_BANK_OVF_FLAG_EN
      .o_ovf   (ovf_o[c]),
`endif
      .o_cnt   (w_cnt[c])
    );
  end

  // Captures pre-update counter values of the latch cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i)        r_snap <= '0;
    else if (latch_i) r_snap <= w_cnt;
  end

  logic [BIT_WIDTH-1:0]      w_sel;
  logic [PAD_W-1:0]          w_pad;
  logic [READ_BIT_WIDTH-1:0] w_word;
  logic                      w_ch_ok;
  logic                      w_word_ok;

  // Compare-based muxes keep out-of-range indices from ever selecting
  // a nonexistent entry; the *_ok flags double as range checks.
  always_comb begin
    w_sel   = '0;
    w_ch_ok = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_ch_i == CH_IDX_W'(c)) begin
        w_sel   = r_snap[c];
        w_ch_ok = 1'b1;
      end
    end
    w_pad     = PAD_W'(w_sel);
    w_word    = '0;
    w_word_ok = 1'b0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (rd_word_i == WORD_IDX_W'(w)) begin
        w_word    = w_pad[w*READ_BIT_WIDTH +: READ_BIT_WIDTH];
        w_word_ok = 1'b1;
      end
    end
  end

  logic                      r_rd_valid;
  logic [READ_BIT_WIDTH-1:0] r_rd_data;
  logic                      r_rd_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_req_i;
      if (rd_req_i) begin
        r_rd_err  <= !(w_ch_ok && w_word_ok);
        r_rd_data <= (w_ch_ok && w_word_ok) ? w_word : '0;
      end
    end
  end

  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;
  assign rd_err_o   = r_rd_err;

endmodule

// File: tb/tb_upcounter_bank.sv
// tb_upcounter_bank: directed + random stimulus against an arithmetic
// reference model of the counter bank (6 channels, 8-bit counters, 3-bit
// read words so the top word is zero-padded, ch1 saturating).
module tb_upcounter_bank;
  localparam int N_CH = 6;
  localparam int BW   = 8;
  localparam int RBW  = 3;
  localparam int INCW = 3;
  localparam int NW   = 3;
  localparam int MAXV = (1 << BW) - 1;
  localparam logic [N_CH-1:0] SMASK = 6'b000010;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_CH*INCW-1:0] countup;
  logic                 latch;
  logic [N_CH-1:0]      clear;
  logic                 rd_req;
  logic [2:0]           rd_ch;
  logic [1:0]           rd_word;
  logic                 rd_valid;
  logic [RBW-1:0]       rd_data;
  logic                 rd_err;
`ifdef UPCOUNTER_BANK_OVF_FLAG_EN
  logic [N_CH-1:0]      ovf;
`endif

  upcounter_bank #(
    .N_CH(N_CH), .BIT_WIDTH(BW), .READ_BIT_WIDTH(RBW),
    .INC_WIDTH(INCW), .SATURATE_MASK(SMASK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .countup_i(countup), .latch_i(latch),
    .clear_i(clear), .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_word_i(rd_word),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
`ifdef UPCOUNTER_BANK_OVF_FLAG_EN
    .ovf_o(ovf),
`endif
    .rd_err_o(rd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cnt  [N_CH];
  int m_snap [N_CH];
  bit m_ovf  [N_CH];
  int m_data;
  bit m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    countup = '0; latch = 1'b0; clear = '0; rd_req = 1'b0;
    rd_ch = '0; rd_word = '0; rst = 1'b0;
  endtask

  // Advance one cycle with the currently driven inputs and check outputs.
  task automatic step();
    bit exp_v;
    exp_v = rd_req && !rst;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        m_cnt[c] = 0; m_snap[c] = 0; m_ovf[c] = 0;
      end
      m_data = 0; m_err = 0;
    end else begin
      if (rd_req) begin
        if (int'(rd_ch) >= N_CH || int'(rd_word) >= NW) begin
          m_data = 0; m_err = 1;
        end else begin
          m_data = (m_snap[rd_ch] / (1 << (int'(rd_word) * RBW))) % (1 << RBW);
          m_err  = 0;
        end
      end
      if (latch) for (int c = 0; c < N_CH; c++) m_snap[c] = m_cnt[c];
      for (int c = 0; c < N_CH; c++) begin
        int sum;
        sum = m_cnt[c] + int'(countup[c*INCW +: INCW]);
        if (clear[c]) begin
          m_cnt[c] = 0; m_ovf[c] = 0;
        end else if (sum > MAXV) begin
          m_ovf[c] = 1;
          m_cnt[c] = SMASK[c] ? MAXV : sum - (MAXV + 1);
        end else begin
          m_cnt[c] = sum;
        end
      end
    end
    @(posedge clk); #1;
    chk("rd_valid", 64'(rd_valid), 64'(exp_v));
    chk("rd_data", 64'(rd_data), 64'(m_data));
    chk("rd_err", 64'(rd_err), 64'(m_err));
`ifdef UPCOUNTER_BANK_OVF_FLAG_EN
    for (int c = 0; c < N_CH; c++) chk("ovf", 64'(ovf[c]), 64'(m_ovf[c]));
`endif
  endtask

  // Read all words of a channel's snapshot back-to-back and reassemble.
  task automatic read_snap(input int ch, output int val);
    val = 0;
    for (int w = 0; w < NW; w++) begin
      idle();
      rd_req = 1'b1; rd_ch = 3'(ch); rd_word = 2'(w);
      step();
      val = val + int'(rd_data) * (1 << (w * RBW));
    end
    idle();
  endtask

  task automatic count(input int ch, input int inc, input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      countup[ch*INCW +: INCW] = INCW'(inc);
      step();
    end
    idle();
  endtask

  task automatic do_latch();
    idle(); latch = 1'b1; step(); idle();
  endtask

  initial begin
    int v;
    idle();
    rst = 1'b1;
    step(); step();
    idle();
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    read_snap(0, v);
    chk("rst_snap0", 64'(v), 64'd0);

    // ch0 counts 5, then latch and read words
    count(0, 1, 5);
    do_latch();
    read_snap(0, v);
    chk("ch0_snap", 64'(v), 64'd5);

    // ch1 saturates at 255
    count(1, 7, 40);
    do_latch();
    read_snap(1, v);
    chk("ch1_sat", 64'(v), 64'd255);

    // ch2 wraps 254 + 3 -> 1
    count(2, 7, 36);
    count(2, 2, 1);
    count(2, 3, 1);
    do_latch();
    read_snap(2, v);
    chk("ch2_wrap", 64'(v), 64'd1);
    idle(); clear[2] = 1'b1; step(); idle();
    do_latch();
    read_snap(2, v);
    chk("ch2_clr", 64'(v), 64'd0);

    // ch3: clear + inc + latch in one cycle
    count(3, 5, 2);
    idle(); clear[3] = 1'b1; countup[3*INCW +: INCW] = 3'd1; latch = 1'b1; step();
    read_snap(3, v);
    chk("ch3_snap_pre", 64'(v), 64'd10);
    do_latch();
    read_snap(3, v);
    chk("ch3_snap_post", 64'(v), 64'd0);

    // latch and read same cycle returns the old snapshot
    count(0, 2, 1);
    idle(); latch = 1'b1; rd_req = 1'b1; rd_ch = 3'd0; rd_word = 2'd0; step();
    chk("latch_rd_old", 64'(rd_data), 64'd5);

    // out-of-range indices
    idle(); rd_req = 1'b1; rd_ch = 3'd6; step();
    chk("err_ch", 64'(rd_err), 64'd1);
    chk("err_ch_data", 64'(rd_data), 64'd0);
    idle(); rd_req = 1'b1; rd_ch = 3'd0; rd_word = 2'd3; step();
    chk("err_word", 64'(rd_err), 64'd1);
    idle(); rd_req = 1'b1; rd_ch = 3'd7; rd_word = 2'd3; step();

    // reset in the request cycle
    idle(); rd_req = 1'b1; rd_ch = 3'd1; rst = 1'b1; step();
    chk("rstrd_valid", 64'(rd_valid), 64'd0);
    chk("rstrd_err", 64'(rd_err), 64'd0);
    idle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      countup = (N_CH*INCW)'($urandom);
      latch   = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < N_CH; c++) clear[c] = ($urandom_range(0, 15) == 0);
      rd_req  = $urandom_range(0, 1);
      rd_ch   = 3'($urandom_range(0, 7));
      rd_word = 2'($urandom_range(0, 3));
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
